// File: rtl/cs01_rxt_top.sv
// CS01 receive-timing top: MIB slave, register file, RXT sample/frame counters and trigger on the north-to-east sample path.
// HS path: 2 clocks pin to pin. MIB: fixed address/data frame, 2 ACK pulses per accepted transaction; unmapped/timed-out ones never ACK.
module cs01_rxt_top #(
  parameter int          P_CMD_ACK_TIMEOUT_CLKS = 16,
  parameter int          SIM_MODE               = 0,
  parameter logic [3:0]  P_MIB_MSN              = 4'h1,
  parameter int          P_FRAME_LEN            = 1024,
  parameter logic [31:0] P_UID                  = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [47:10] HS_NORTH_IN,
  output logic [47:10] HS_EAST_OUT,
  output logic         FPGA_LED,
  input  logic         MIB_START,
  input  logic         MIB_RD_WR_N,
  output logic         MIB_ACK,
  inout  wire  [15:0]  MIB_AD
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR2   = 3'd1;
  localparam logic [2:0] S_WAIT_RF = 3'd2;
  localparam logic [2:0] S_DATA1   = 3'd3;
  localparam logic [2:0] S_DATA2   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [31:0] FL_W    = 32'(P_FRAME_LEN);
  localparam logic [15:0] TO_LAST = 16'(P_CMD_ACK_TIMEOUT_CLKS - 1);
  localparam logic [31:0] UID     = (SIM_MODE != 0) ? 32'h5117_C501 : P_UID;

  // IO registers
  logic         start_q, rdwr_q;
  logic [15:0]  ad_in_q;
  logic [47:11] hs_q;
  logic         unused_hs10;
  logic         mib_ack_q, ad_oe_q;
  logic [15:0]  ad_q;

  assign unused_hs10 = HS_NORTH_IN[10];
  assign MIB_AD      = ad_oe_q ? ad_q : 16'hzzzz;
  assign MIB_ACK     = mib_ack_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_q <= 1'b0;
      rdwr_q  <= 1'b0;
      ad_in_q <= '0;
      hs_q    <= '0;
    end else begin
      start_q <= MIB_START;
      rdwr_q  <= MIB_RD_WR_N;
      ad_in_q <= MIB_AD;
      hs_q    <= HS_NORTH_IN[47:11];
    end
  end

  // MIB slave FSM
  logic [2:0]  state_q, state_d;
  logic        rd_q, rd_d;
  logic        ack_ph_q, ack_ph_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [15:0] addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rf_sel_q, rf_sel_d;
  logic        rf_ack_q;
  logic [31:0] rf_rdata_q;
  logic        data_ph;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    ack_ph_d  = ack_ph_q;
    addr_hi_d = addr_hi_q;
    addr_lo_d = addr_lo_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rf_sel_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          addr_hi_d = ad_in_q[7:0];
          rd_d      = rdwr_q;
          ack_ph_d  = 1'b0;
          state_d   = S_ADDR2;
        end
      end
      S_ADDR2: begin
        addr_lo_d = ad_in_q;
        if (addr_hi_q[7:4] != P_MIB_MSN) begin
          state_d = S_IDLE;
        end else if (rd_q) begin
          state_d  = S_WAIT_RF;
          rf_sel_d = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d = S_DATA1;
        end
      end
      S_WAIT_RF: begin
        if (rf_ack_q) begin
          state_d  = S_DATA1;
          ack_ph_d = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // DATA1/DATA2 capture write words before the RF access, then carry the ACKs after it
      S_DATA1: begin
        if (!ack_ph_q) wdata_d[31:16] = ad_in_q;
        state_d = S_DATA2;
      end
      S_DATA2: begin
        if (ack_ph_q) begin
          state_d = S_DONE;
        end else begin
          wdata_d[15:0] = ad_in_q;
          state_d       = S_WAIT_RF;
          rf_sel_d      = 1'b1;
          cnt_d         = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && start_q) begin
      addr_hi_d = ad_in_q[7:0];
      rd_d      = rdwr_q;
      ack_ph_d  = 1'b0;
      rf_sel_d  = 1'b0;
      state_d   = S_ADDR2;
    end
  end

  assign data_ph = ack_ph_q && (state_q == S_DATA1 || state_q == S_DATA2);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      rd_q      <= 1'b0;
      ack_ph_q  <= 1'b0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rf_sel_q  <= 1'b0;
      mib_ack_q <= 1'b0;
      ad_oe_q   <= 1'b0;
      ad_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      ack_ph_q  <= ack_ph_d;
      addr_hi_q <= addr_hi_d;
      addr_lo_q <= addr_lo_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rf_sel_q  <= rf_sel_d;
      mib_ack_q <= data_ph;
      ad_oe_q   <= data_ph && rd_q;
      ad_q      <= (state_q == S_DATA1) ? rf_rdata_q[31:16] : rf_rdata_q[15:0];
    end
  end

  // Register file
  logic [19:0] rf_addr;
  logic        rf_hit;
  logic [31:0] rf_rd;
  logic        wr_en, win_wr, tgt_wr;
  logic [31:0] scratch_q, tgt_frame_q;
  logic [9:0]  win_q, tgt_samp_q;
  logic [31:0] unal_samp_q, unal_frame_q, al_frame_q;
  logic [31:0] al_cur;

  assign rf_addr = {addr_hi_q[3:0], addr_lo_q};

  always_comb begin
    rf_hit = 1'b1;
    rf_rd  = '0;
    case (rf_addr)
      20'h00000: rf_rd = UID;
      20'h00004: rf_rd = scratch_q;
      20'h10000: rf_rd = {22'd0, win_q};
      20'h10004: rf_rd = al_cur;
      20'h10008: rf_rd = al_frame_q;
      20'h1000C: rf_rd = unal_samp_q;
      20'h10010: rf_rd = unal_frame_q;
      20'h10014: rf_rd = tgt_frame_q;
      20'h10018: rf_rd = {22'd0, tgt_samp_q};
      default:   rf_hit = 1'b0;
    endcase
  end

  assign wr_en  = rf_sel_q && !rd_q && rf_hit;
  assign win_wr = wr_en && (rf_addr == 20'h10000);
  assign tgt_wr = wr_en && (rf_addr == 20'h10014 || rf_addr == 20'h10018);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf_ack_q    <= 1'b0;
      rf_rdata_q  <= '0;
      scratch_q   <= '0;
      win_q       <= '0;
      tgt_frame_q <= '0;
      tgt_samp_q  <= '0;
    end else begin
      rf_ack_q <= rf_sel_q && rf_hit;
      if (rf_sel_q) rf_rdata_q <= rf_rd;
      if (wr_en && rf_addr == 20'h00004) scratch_q   <= wdata_q;
      if (win_wr)                        win_q       <= wdata_q[9:0];
      if (wr_en && rf_addr == 20'h10014) tgt_frame_q <= wdata_q;
      if (wr_en && rf_addr == 20'h10018) tgt_samp_q  <= wdata_q[9:0];
    end
  end

  // RXT counters and trigger
  logic [31:0] win_mod, unal_nxt;
  logic [31:0] unal_samp_d, unal_frame_d, al_frame_d;
  logic        al_sync_q, al_sync_d;
  logic        armed_q, armed_d;
  logic        trig_d;
  logic        hs_vld;
  logic        led_q;
  logic [47:10] hs_out_q;

  function automatic logic [31:0] al_of(input logic [31:0] u, input logic [31:0] w);
    logic [31:0] s;
    s = u + FL_W - w;
    return (s >= FL_W) ? s - FL_W : s;
  endfunction

  assign hs_vld   = hs_q[47];
  assign win_mod  = {22'd0, win_q} % FL_W;
  assign al_cur   = al_of(unal_samp_q, win_mod);
  assign unal_nxt = (unal_samp_q == FL_W - 32'd1) ? 32'd0 : unal_samp_q + 32'd1;

  always_comb begin
    unal_samp_d  = unal_samp_q;
    unal_frame_d = unal_frame_q;
    al_frame_d   = al_frame_q;
    al_sync_d    = al_sync_q;
    armed_d      = armed_q;
    trig_d       = 1'b0;
    if (hs_vld) begin
      unal_samp_d = unal_nxt;
      if (unal_nxt == 32'd0) unal_frame_d = unal_frame_q + 32'd1;
      // The first aligned boundary after reset or a window change opens aligned frame 0
      if (al_of(unal_nxt, win_mod) == 32'd0) begin
        if (al_sync_q) al_frame_d = al_frame_q + 32'd1;
        else           al_sync_d  = 1'b1;
      end
      if (armed_q && al_frame_q == tgt_frame_q && al_cur == {22'd0, tgt_samp_q}) begin
        trig_d  = 1'b1;
        armed_d = 1'b0;
      end
    end
    if (win_wr) begin
      al_frame_d = '0;
      al_sync_d  = 1'b0;
    end
    if (tgt_wr) armed_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      unal_samp_q  <= '0;
      unal_frame_q <= '0;
      al_frame_q   <= '0;
      al_sync_q    <= 1'b0;
      armed_q      <= 1'b0;
      hs_out_q     <= '0;
      led_q        <= 1'b0;
    end else begin
      unal_samp_q  <= unal_samp_d;
      unal_frame_q <= unal_frame_d;
      al_frame_q   <= al_frame_d;
      al_sync_q    <= al_sync_d;
      armed_q      <= armed_d;
      hs_out_q     <= {hs_q[47:11], trig_d};
      led_q        <= led_q ^ trig_d;
    end
  end

  assign HS_EAST_OUT = hs_out_q;
  assign FPGA_LED    = led_q;

endmodule

// File: tb/tb_cs01_rxt_top.sv
// Bench for cs01_rxt_top: table-driven MIB register vectors, scoreboarded sample stream, hand-written corner sequences.
module tb_cs01_rxt_top;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic [47:10] HS_NORTH_IN = '0;
  logic [47:10] HS_EAST_OUT;
  logic         FPGA_LED;
  logic         MIB_START = 1'b0;
  logic         MIB_RD_WR_N = 1'b0;
  logic         MIB_ACK;
  wire  [15:0]  mib_ad;
  logic         tb_oe = 1'b0;
  logic [15:0]  tb_ad = '0;

  assign mib_ad = tb_oe ? tb_ad : 16'hzzzz;

  cs01_rxt_top #(.SIM_MODE(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .HS_NORTH_IN(HS_NORTH_IN), .HS_EAST_OUT(HS_EAST_OUT),
    .FPGA_LED(FPGA_LED), .MIB_START(MIB_START), .MIB_RD_WR_N(MIB_RD_WR_N),
    .MIB_ACK(MIB_ACK), .MIB_AD(mib_ad)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard for the sample path
  logic [47:10] exp_q[$];
  logic         mon_en = 1'b0;
  int           trig_cnt = 0;

  always @(negedge CLK) begin
    if (mon_en && RST_N && HS_EAST_OUT[47]) begin
      if (HS_EAST_OUT[10]) trig_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: unexpected output 0x%010h", HS_EAST_OUT);
      end else begin
        logic [47:10] e;
        e = exp_q.pop_front();
        n_tests++;
        if (HS_EAST_OUT !== e) begin
          n_fail++;
          $display("FAIL sb_sample: got 0x%010h, expected 0x%010h", HS_EAST_OUT, e);
        end
      end
    end
  end

  task automatic stream(input int n, input int trig_idx);
    for (int i = 0; i < n; i++) begin
      logic [47:10] s;
      if (i % 13 == 5) begin
        @(negedge CLK);
        HS_NORTH_IN = {1'b0, 5'($urandom), 32'($urandom)};
      end
      s = {1'b1, 5'($urandom), 32'($urandom)};
      @(negedge CLK);
      HS_NORTH_IN = s;
      exp_q.push_back({s[47:11], (i == trig_idx)});
    end
    @(negedge CLK);
    HS_NORTH_IN = '0;
    repeat (4) @(negedge CLK);
    check32("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drive_mib(input logic st, input logic rd, input logic oe, input logic [15:0] ad);
    @(negedge CLK);
    MIB_START   = st;
    MIB_RD_WR_N = rd;
    tb_oe       = oe;
    tb_ad       = ad;
  endtask

  task automatic collect(output int acks, output logic [31:0] rdata, output logic oe_seen);
    acks    = 0;
    rdata   = '0;
    oe_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (dut.ad_oe_q) oe_seen = 1'b1;
      if (MIB_ACK) begin
        acks++;
        rdata = {rdata[15:0], mib_ad};
      end
    end
  endtask

  task automatic mib_xfer(input logic [23:0] addr, input logic rd, input logic [31:0] wdata,
                          output int acks, output logic [31:0] rdata, output logic oe_seen);
    drive_mib(1'b1, rd, 1'b1, {8'h00, addr[23:16]});
    drive_mib(1'b0, rd, 1'b1, addr[15:0]);
    if (!rd) begin
      drive_mib(1'b0, 1'b0, 1'b1, wdata[31:16]);
      drive_mib(1'b0, 1'b0, 1'b1, wdata[15:0]);
    end
    drive_mib(1'b0, 1'b0, 1'b0, 16'h0000);
    collect(acks, rdata, oe_seen);
  endtask

  task automatic reg_wr(input logic [23:0] addr, input logic [31:0] wdata);
    int a; logic [31:0] r; logic oe;
    mib_xfer(addr, 1'b0, wdata, a, r, oe);
    check32("wr_acks", 32'(a), 32'd2);
  endtask

  task automatic reg_rd(input string name, input logic [23:0] addr, input logic [31:0] exp);
    int a; logic [31:0] r; logic oe;
    mib_xfer(addr, 1'b1, 32'd0, a, r, oe);
    check32({name, "_acks"}, 32'(a), 32'd2);
    check32(name, r, exp);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic        rd;
    logic [31:0] wdata;
    int          exp_acks;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int          acks;
    logic [31:0] rdata;
    logic        oe_seen;
    logic [47:10] smp;
    int          waited;

    tbl[0]  = '{24'h100004, 1'b0, 32'h0101_0202, 2, 32'h0};
    tbl[1]  = '{24'h100004, 1'b1, 32'h0,         2, 32'h0101_0202};
    tbl[2]  = '{24'h100000, 1'b1, 32'h0,         2, 32'h5117_C501};
    tbl[3]  = '{24'h200000, 1'b0, 32'hFFFF_0000, 0, 32'h0};
    tbl[4]  = '{24'h120000, 1'b1, 32'h0,         0, 32'h0};
    tbl[5]  = '{24'h100004, 1'b1, 32'h0,         2, 32'h0101_0202};
    tbl[6]  = '{24'h110000, 1'b0, 32'h0001_2345, 2, 32'h0};
    tbl[7]  = '{24'h110000, 1'b1, 32'h0,         2, 32'h0000_0345};
    tbl[8]  = '{24'h110004, 1'b1, 32'h0,         2, 32'h0000_00BB};
    tbl[9]  = '{24'h11000C, 1'b0, 32'hDEAD_BEEF, 2, 32'h0};
    tbl[10] = '{24'h11000C, 1'b1, 32'h0,         2, 32'h0};
    tbl[11] = '{24'h110014, 1'b0, 32'hCAFE_BABE, 2, 32'h0};
    tbl[12] = '{24'h110014, 1'b1, 32'h0,         2, 32'hCAFE_BABE};
    tbl[13] = '{24'h200004, 1'b1, 32'h0,         0, 32'h0};

    // Reset state
    #1;
    check32("rst_hs_out", 32'(HS_EAST_OUT), 32'd0);
    check32("rst_led",    32'(FPGA_LED),    32'd0);
    check32("rst_ack",    32'(MIB_ACK),     32'd0);
    check32("rst_ad_oe",  32'(dut.ad_oe_q), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 14; i++) begin
      mib_xfer(tbl[i].addr, tbl[i].rd, tbl[i].wdata, acks, rdata, oe_seen);
      check32($sformatf("vec%0d_acks", i), 32'(acks), 32'(tbl[i].exp_acks));
      check32($sformatf("vec%0d_ad_oe", i), 32'(oe_seen), 32'(tbl[i].rd && tbl[i].exp_acks > 0));
      if (tbl[i].rd && tbl[i].exp_acks > 0)
        check32($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
    end

    // START during an unfinished write restarts the frame as a read
    drive_mib(1'b1, 1'b0, 1'b1, 16'h0010);
    drive_mib(1'b0, 1'b0, 1'b1, 16'h0004);
    drive_mib(1'b1, 1'b1, 1'b1, 16'h0010);
    drive_mib(1'b0, 1'b1, 1'b1, 16'h0004);
    drive_mib(1'b0, 1'b0, 1'b0, 16'h0000);
    collect(acks, rdata, oe_seen);
    check32("restart_acks",  32'(acks), 32'd2);
    check32("restart_rdata", rdata, 32'h0101_0202);

    // Pin-to-pin latency of the sample path
    smp = 38'h3A_5A5A_C3C3 | (38'd1 << 37);
    @(negedge CLK);
    HS_NORTH_IN = smp;
    @(negedge CLK);
    HS_NORTH_IN = '0;
    check32("lat_1clk", 32'(HS_EAST_OUT[47]), 32'd0);
    @(negedge CLK);
    check32("lat_2clk", HS_EAST_OUT[47:16], {smp[47:16]});
    check32("lat_2clk_lo", 32'(HS_EAST_OUT[15:10]), 32'({smp[15:11], 1'b0}));

    // Counters after 1000 valid samples with window 0x64
    do_reset();
    reg_wr(24'h110000, 32'h64);
    mon_en = 1'b1;
    trig_cnt = 0;
    stream(1000, -1);
    reg_rd("unal_samp",  24'h11000C, 32'd1000);
    reg_rd("unal_frame", 24'h110010, 32'd0);
    reg_rd("al_samp",    24'h110004, 32'd900);
    reg_rd("al_frame",   24'h110008, 32'd0);
    check32("no_trig", 32'(trig_cnt), 32'd0);

    // Trigger at aligned frame 1, aligned sample 0x1DC
    do_reset();
    reg_wr(24'h110000, 32'h64);
    reg_wr(24'h110014, 32'h1);
    reg_wr(24'h110018, 32'h1DC);
    trig_cnt = 0;
    stream(2200, 1600);
    check32("trig_cnt", 32'(trig_cnt), 32'd1);
    check32("led_on",   32'(FPGA_LED), 32'd1);
    reg_rd("unal_samp2",  24'h11000C, 32'd152);
    reg_rd("unal_frame2", 24'h110010, 32'd2);
    reg_rd("al_samp2",    24'h110004, 32'd52);
    reg_rd("al_frame2",   24'h110008, 32'd2);

    // Reset in the middle of a read data phase, with counters running
    stream(300, -1);
    mon_en = 1'b0;
    drive_mib(1'b1, 1'b1, 1'b1, 16'h0011);
    drive_mib(1'b0, 1'b1, 1'b1, 16'h000C);
    drive_mib(1'b0, 1'b0, 1'b0, 16'h0000);
    waited = 0;
    while (!dut.ad_oe_q && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    check32("pre_rst_ad_oe", 32'(dut.ad_oe_q), 32'd1);
    RST_N = 1'b0;
    #1;
    check32("mid_rst_ad_oe", 32'(dut.ad_oe_q), 32'd0);
    check32("mid_rst_ack",   32'(MIB_ACK),     32'd0);
    check32("mid_rst_led",   32'(FPGA_LED),    32'd0);
    check32("mid_rst_hs",    32'(HS_EAST_OUT), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    reg_rd("rst_unal_samp",  24'h11000C, 32'd0);
    reg_rd("rst_unal_frame", 24'h110010, 32'd0);
    reg_rd("rst_al_frame",   24'h110008, 32'd0);
    reg_rd("rst_win",        24'h110000, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
